// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store memory stage.
//   - RV32I funct3 width codes for loads and stores
//   - FSM state encoding
//   - byte-enable width and an op-legality helper
package lsu_pkg;

  localparam int unsigned BE_W = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  // Stores only have signed-width encodings; the unsigned codes are loads only.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) begin
      ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end else begin
      ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: purely combinational byte-lane steering for the LSU.
//   Store side: st_funct3_i/st_off_i/st_data_i -> st_be_o (byte enables), st_wdata_o
//               (store data replicated across all lanes of its width).
//   Load side:  ld_funct3_i/ld_off_i/ld_rdata_i -> ld_data_o (selected byte/half,
//               sign- or zero-extended, or the full word).
// The caller supplies offsets already cleared for the access size when needed.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      st_funct3_i,
  input  logic [1:0]      st_off_i,
  input  logic [XLEN-1:0] st_data_i,
  output logic [BE_W-1:0] st_be_o,
  output logic [XLEN-1:0] st_wdata_o,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_off_i,
  input  logic [XLEN-1:0] ld_rdata_i,
  output logic [XLEN-1:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be_o    = '0;
    st_wdata_o = st_data_i;
    unique case (st_funct3_i)
      F3_SB: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {(XLEN/8){st_data_i[7:0]}};
      end
      F3_SH: begin
        st_be_o    = 4'b0011 << {st_off_i[1], 1'b0};
        st_wdata_o = {(XLEN/16){st_data_i[15:0]}};
      end
      F3_SW: begin
        st_be_o = 4'b1111;
      end
      default: begin
        st_be_o = '0;
      end
    endcase
  end

  always_comb begin
    ld_byte   = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
    ld_half   = ld_rdata_i[{ld_off_i[1], 4'b0000} +: 16];
    ld_data_o = '0;
    unique case (ld_funct3_i)
      F3_LB:   ld_data_o = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data_o = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_LW:   ld_data_o = ld_rdata_i;
      F3_LBU:  ld_data_o = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LHU:  ld_data_o = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store unit sitting after the ALU.
//   Core side: req_valid/mem_read/mem_write/funct3/addr/store_data in;
//              busy (combinational stall), done pulse, load_data, misaligned out.
//   Bus side:  bus_req/bus_we/bus_addr/bus_wdata/bus_be out (registered);
//              bus_gnt/bus_rvalid/bus_rdata in.
// Build option: define LSU_MISALIGN_TRAP_EN to turn misaligned half/word accesses into
// a misaligned pulse with no bus access; otherwise the offending low address bits are
// cleared and the access proceeds.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   store_data,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   load_data,
  output logic              misaligned,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [BE_W-1:0]   bus_be,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata
);

  lsu_state_e        state_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic              done_q;
  logic              mis_q;
  logic [XLEN-1:0]   load_data_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [XLEN-1:0]   bus_wdata_q;
  logic [BE_W-1:0]   bus_be_q;

  logic            start;
  logic            legal;
  logic            trap;
  logic            size_half;
  logic            size_word;
  logic [1:0]      eff_off;
  logic [BE_W-1:0] st_be;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] ld_ext;

  assign start     = (state_q == IDLE) && req_valid && (mem_read || mem_write);
  assign legal     = f3_legal(mem_write, funct3);
  assign size_half = (funct3[1:0] == 2'b01);
  assign size_word = (funct3[1:0] == 2'b10);

  // Low bits that cannot be honoured for the access size are dropped.
  always_comb begin
    eff_off = addr[1:0];
    if (size_word) begin
      eff_off = 2'b00;
    end else if (size_half) begin
      eff_off[0] = 1'b0;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = (size_half && addr[0]) || (size_word && (addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  lsu_lane_align #(
    .XLEN(XLEN)
  ) u_lane_align (
    .st_funct3_i(funct3),
    .st_off_i   (eff_off),
    .st_data_i  (store_data),
    .st_be_o    (st_be),
    .st_wdata_o (st_wdata),
    .ld_funct3_i(funct3_q),
    .ld_off_i   (off_q),
    .ld_rdata_i (bus_rdata),
    .ld_data_o  (ld_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
      load_data_q <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
    end else begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            we_q     <= mem_write;
            funct3_q <= funct3;
            off_q    <= eff_off;
            if (!legal || trap) begin
              // Rejected access: finish without touching the bus.
              state_q     <= DONE;
              done_q      <= 1'b1;
              mis_q       <= legal && trap;
              load_data_q <= '0;
            end else begin
              state_q     <= REQ;
              bus_req_q   <= 1'b1;
              bus_we_q    <= mem_write;
              bus_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
              bus_be_q    <= mem_write ? st_be : '0;
              bus_wdata_q <= st_wdata;
            end
          end
        end
        REQ: begin
          if (bus_gnt) begin
            bus_req_q <= 1'b0;
            if (we_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (bus_rvalid) begin
              load_data_q <= ld_ext;
              state_q     <= DONE;
              done_q      <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus_rvalid) begin
            load_data_q <= ld_ext;
            state_q     <= DONE;
            done_q      <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = start || (state_q == REQ) || (state_q == WAIT);
  assign done       = done_q;
  assign misaligned = mis_q;
  assign load_data  = load_data_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_be     = bus_be_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Testbench for lsu_mem_stage: directed cases with literal expectations plus randomized
// transactions checked every cycle against a transaction-level model.
module tb_lsu_mem_stage;
  import lsu_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        busy, done, misaligned, bus_req, bus_we;
  logic [31:0] load_data, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;

  int errors = 0;
  int checks = 0;

  // Per-cycle expectations produced by the stimulus/model.
  bit          cmp_en = 1'b0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_req = 1'b0, m_mis = 1'b0, m_we = 1'b0;
  logic [31:0] m_ld = '0, m_addr = '0, m_wdata = '0;
  logic [3:0]  m_be = '0;

  always #5 clk = ~clk;

  lsu_mem_stage #(
    .XLEN  (32),
    .ADDR_W(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .store_data(store_data),
    .busy      (busy),
    .done      (done),
    .load_data (load_data),
    .misaligned(misaligned),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_gnt   (bus_gnt),
    .bus_rvalid(bus_rvalid),
    .bus_rdata (bus_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("bus_req", 32'(bus_req), 32'(m_req));
      chk("misaligned", 32'(misaligned), 32'(m_mis));
      chk("load_data", load_data, m_ld);
      if (m_req) begin
        chk("bus_we", 32'(bus_we), 32'(m_we));
        chk("bus_addr", bus_addr, m_addr);
        chk("bus_be", 32'(bus_be), 32'(m_be));
        if (m_we) chk("bus_wdata", bus_wdata, m_wdata);
      end
    end
  end

  // Transaction-level reference: what a single access must produce.
  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rdat,
                                output bit legal, output bit trap, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] ld);
    int sz, off;
    bit mis;
    logic [31:0] v;
    sz = int'(f3[1:0]);
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    mis  = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
    trap = legal && mis && Trap;
    if (sz == 2)      off = 0;
    else if (sz == 1) off = int'(a[1]) * 2;
    else              off = int'(a[1:0]);
    v = rdat >> (8 * off);
    if (sz == 0) begin
      be = 4'(1 << off);
      wd = (sd & 32'hFF) * 32'h01010101;
      ld = v & 32'hFF;
      if (!f3[2] && ld >= 32'd128) ld = ld | 32'hFFFFFF00;
    end else if (sz == 1) begin
      be = 4'(3 << off);
      wd = (sd & 32'hFFFF) * 32'h00010001;
      ld = v & 32'hFFFF;
      if (!f3[2] && ld >= 32'd32768) ld = ld | 32'hFFFF0000;
    end else begin
      be = 4'hF;
      wd = sd;
      ld = rdat;
    end
    if (!we) be = 4'h0;
  endfunction

  task automatic idle_cycle(input bit noise);
    @(posedge clk); #1;
    req_valid  = noise ? 1'($urandom) : 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    bus_gnt    = noise ? 1'($urandom) : 1'b0;
    bus_rvalid = noise ? 1'($urandom) : 1'b0;
    bus_rdata  = $urandom;
    m_busy = 1'b0; m_done = 1'b0; m_req = 1'b0; m_mis = 1'b0;
  endtask

  // lit[0]: check bus fields against literals in the first REQ cycle.
  // lit[1]: check load_data against a literal in the done cycle.
  task automatic run_op(input bit we, input bit rd, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rdat, input int gd,
                        input int rdd, input int lit, input logic [31:0] lit_addr,
                        input logic [3:0] lit_be, input logic [31:0] lit_wd,
                        input logic [31:0] lit_ld);
    bit legal, trap;
    logic [3:0] be;
    logic [31:0] wd, ld;
    model(we, f3, a, sd, rdat, legal, trap, be, wd, ld);
    @(posedge clk); #1;
    req_valid = 1'b1; mem_read = rd; mem_write = we; funct3 = f3; addr = a; store_data = sd;
    bus_gnt = 1'($urandom); bus_rvalid = 1'($urandom); bus_rdata = $urandom;
    m_busy = 1'b1; m_done = 1'b0; m_req = 1'b0; m_mis = 1'b0;
    if (legal && !trap) begin
      m_addr = {a[31:2], 2'b00}; m_be = be; m_wdata = wd; m_we = we;
      for (int i = 0; i <= gd; i++) begin
        @(posedge clk); #1;
        bus_gnt    = (i == gd);
        bus_rvalid = (i == gd) && !we && (rdd == 0);
        bus_rdata  = bus_rvalid ? rdat : $urandom;
        m_req = 1'b1;
        if (i == 0 && lit[0]) begin
          @(negedge clk);
          chk("lit_bus_addr", bus_addr, lit_addr);
          chk("lit_bus_be", 32'(bus_be), 32'(lit_be));
          chk("lit_bus_we", 32'(bus_we), 32'(we));
          if (we) chk("lit_bus_wdata", bus_wdata, lit_wd);
        end
      end
      if (!we) begin
        for (int j = 1; j <= rdd; j++) begin
          @(posedge clk); #1;
          bus_gnt    = 1'($urandom);
          bus_rvalid = (j == rdd);
          bus_rdata  = (j == rdd) ? rdat : $urandom;
          m_req = 1'b0;
        end
      end else begin
        ld = m_ld;
      end
    end else begin
      ld = 32'h0;
    end
    @(posedge clk); #1;
    req_valid = 1'($urandom);
    bus_gnt = 1'($urandom); bus_rvalid = 1'($urandom); bus_rdata = $urandom;
    m_busy = 1'b0; m_done = 1'b1; m_req = 1'b0; m_mis = trap; m_ld = ld;
    if (lit[1]) begin
      @(negedge clk);
      chk("lit_load_data", load_data, lit_ld);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    m_done = 1'b0; m_mis = 1'b0;
  endtask

  initial begin
    bit we, rd;
    int op;
    rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0;
    addr = '0; store_data = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_bus_be", 32'(bus_be), 32'h0);
    chk("rst_misaligned", 32'(misaligned), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Stores with literal lane checks.
    run_op(1, 0, F3_SW, 32'h100, 32'hDEADBEEF, 0, 2, 0, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 0);
    run_op(1, 0, F3_SB, 32'h103, 32'h000000A5, 0, 0, 0, 1, 32'h100, 4'b1000, 32'hA5A5A5A5, 0);
    run_op(1, 0, F3_SH, 32'h102, 32'h00001234, 0, 1, 0, 1, 32'h100, 4'b1100, 32'h12341234, 0);
    // Misaligned word load and illegal funct3.
    run_op(0, 1, F3_LW, 32'h101, 0, 32'h12F45678, 0, 0, Trap ? 2 : 3, 32'h100, 4'b0000, 0,
           Trap ? 32'h0 : 32'h12F45678);
    run_op(0, 1, 3'b011, 32'h100, 0, 32'h12F45678, 0, 0, 2, 0, 0, 0, 32'h0);
    run_op(1, 0, 3'b100, 32'h100, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0);
    // Loads with gnt and rvalid together.
    run_op(0, 1, F3_LB,  32'h102, 0, 32'h12F45678, 0, 0, 3, 32'h100, 4'b0000, 0, 32'hFFFFFFF4);
    run_op(0, 1, F3_LBU, 32'h102, 0, 32'h12F45678, 0, 0, 2, 0, 0, 0, 32'h000000F4);
    run_op(0, 1, F3_LH,  32'h102, 0, 32'h12F45678, 0, 0, 2, 0, 0, 0, 32'h000012F4);
    run_op(0, 1, F3_LW,  32'h100, 0, 32'h12F45678, 0, 2, 2, 0, 0, 0, 32'h12F45678);

    // Reset while waiting for read data, followed by a stale rvalid.
    cmp_en = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_LW; addr = 32'h200;
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(negedge clk);
    chk("wait_busy", 32'(busy), 32'h1);
    chk("wait_bus_req", 32'(bus_req), 32'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    chk("rst_wait_busy", 32'(busy), 32'h0);
    chk("rst_wait_load_data", load_data, 32'h0);
    @(posedge clk); #1;
    bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("stale_done_a", 32'(done), 32'h0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk("stale_done_b", 32'(done), 32'h0);
    chk("stale_busy", 32'(busy), 32'h0);
    chk("stale_load_data", load_data, 32'h0);
    m_busy = 1'b0; m_done = 1'b0; m_req = 1'b0; m_mis = 1'b0; m_ld = '0;
    cmp_en = 1'b1;

    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 2)) idle_cycle(1'b1);
      op = $urandom_range(0, 2);
      we = (op != 0);
      rd = (op != 1);
      run_op(we, rd, 3'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 3),
             $urandom_range(0, 3), 0, 0, 0, 0, 0);
    end
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
